// File: rtl/pwm_peripheral_if.sv
// Register-file side of the PWM block: channel enables, modes and duty in, pin levels and
// the period marker out.
interface pwm_peripheral_if #(
    parameter int unsigned NUM_CH = 16
);
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm_mode;
    logic [7:0]        pwm_duty_cycle;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;

    modport master (
        output en_out,
        output en_pwm_mode,
        output pwm_duty_cycle,
        input  pwm_out,
        input  period_start
    );

    modport slave (
        input  en_out,
        input  en_pwm_mode,
        input  pwm_duty_cycle,
        output pwm_out,
        output period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// Shared 8-bit PWM generator driving NUM_CH pins (off, static high or PWM per channel).
// The duty value is shadowed and only taken up at the period boundary.
module pwm_peripheral #(
    parameter int unsigned NUM_CH   = 16,
    parameter int unsigned PRESCALE = 13
) (
    input logic             clk,
    input logic             rst,
    pwm_peripheral_if.slave bus
);
    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

    logic [PreW-1:0]   pre_cnt_q, pre_cnt_d;
    logic [7:0]        pwm_cnt_q, pwm_cnt_d;
    logic [7:0]        duty_sh_q, duty_sh_d;
    logic [NUM_CH-1:0] pwm_out_q, pwm_out_d;
    logic              period_start_q, period_start_d;
    logic              tick;
    logic              wrap;
    logic              pwm_lvl;

    always_comb begin
        tick      = (pre_cnt_q == PreMax);
        wrap      = tick && (pwm_cnt_q == 8'hFF);
        pre_cnt_d = tick ? '0 : pre_cnt_q + PreW'(1);
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        // New duty lands on the same edge the counter returns to 0.
        duty_sh_d = wrap ? bus.pwm_duty_cycle : duty_sh_q;
        // 8'hFF is special-cased so a full-on channel has no one-step gap at count 255.
        pwm_lvl   = (duty_sh_q == 8'hFF) || (pwm_cnt_q < duty_sh_q);
        pwm_out_d = bus.en_out & (~bus.en_pwm_mode | {NUM_CH{pwm_lvl}});
        period_start_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            duty_sh_q      <= '0;
            pwm_out_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            duty_sh_q      <= duty_sh_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
        end
    end

    assign bus.pwm_out      = pwm_out_q;
    assign bus.period_start = period_start_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: a PRESCALE=1 instance for cycle-exact period checks and
// a PRESCALE=13 instance for the mixed-channel case.
module tb_pwm_peripheral;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pwm_peripheral_if #(.NUM_CH(16)) bus1 ();
    pwm_peripheral_if #(.NUM_CH(16)) bus13 ();

    pwm_peripheral #(.NUM_CH(16), .PRESCALE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    pwm_peripheral #(.NUM_CH(16), .PRESCALE(13)) dut13 (
        .clk (clk),
        .rst (rst),
        .bus (bus13)
    );

    typedef struct {
        logic [15:0] en;
        logic [15:0] mode;
        logic [7:0]  duty;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until the selected instance shows period_start, within limit cycles.
    task automatic wait_ps(input bit sel13, input int limit, input string name);
        int  n;
        logic ps;
        n = 0;
        do begin
            step();
            n++;
            ps = sel13 ? bus13.period_start : bus1.period_start;
        end while (!ps && n < limit);
        check(name, {31'd0, ps}, 32'd1);
    endtask

    // Runs n cycles on the PRESCALE=1 instance, profiling bit 0 and period_start.
    // first_low is the 1-based index of the first low sample (0 if none).
    task automatic run1(input int n, input int chg_at, input logic [7:0] chg_duty,
                        output int highs, output int first_low, output int ps_cnt,
                        output int last_ps, output int other_hi);
        highs = 0; first_low = 0; ps_cnt = 0; last_ps = 0; other_hi = 0;
        for (int j = 1; j <= n; j++) begin
            step();
            if (bus1.pwm_out[0]) highs++;
            else if (first_low == 0) first_low = j;
            if (bus1.pwm_out[15:1] != 15'd0) other_hi++;
            if (bus1.period_start) begin
                ps_cnt++;
                last_ps = j;
            end
            if (j == chg_at) bus1.pwm_duty_cycle = chg_duty;
        end
    endtask

    initial begin
        int          highs, first_low, ps_cnt, last_ps, other_hi, bad;
        logic [7:0]  cur_duty;
        logic [15:0] v;

        // duty 0 / 255 make the PWM level phase-independent: expected = en & (~mode | lvl)
        vecs[0] = '{en: 16'hFFFF, mode: 16'h0000, duty: 8'hFF, exp: 16'hFFFF};
        vecs[1] = '{en: 16'hA5A5, mode: 16'hFFFF, duty: 8'hFF, exp: 16'hA5A5};
        vecs[2] = '{en: 16'h0000, mode: 16'hFFFF, duty: 8'hFF, exp: 16'h0000};
        vecs[3] = '{en: 16'hC3C3, mode: 16'h3C3C, duty: 8'hFF, exp: 16'hC3C3};
        vecs[4] = '{en: 16'hFFFF, mode: 16'hFFFF, duty: 8'h00, exp: 16'h0000};
        vecs[5] = '{en: 16'hFFFF, mode: 16'h00FF, duty: 8'h00, exp: 16'hFF00};
        vecs[6] = '{en: 16'hF0F0, mode: 16'hFF00, duty: 8'h00, exp: 16'h00F0};
        vecs[7] = '{en: 16'h1234, mode: 16'h0F0F, duty: 8'h00, exp: 16'h1030};

        // Reset: static-high channels, outputs 0 during reset, all-ones one edge after.
        rst = 1'b1;
        bus1.en_out = 16'hFFFF;
        bus1.en_pwm_mode = 16'h0000;
        bus1.pwm_duty_cycle = 8'h80;
        bus13.en_out = 16'hF0F0;
        bus13.en_pwm_mode = 16'hFF00;
        bus13.pwm_duty_cycle = 8'h20;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst pwm_out", {16'd0, bus1.pwm_out}, 32'd0);
            check("rst period_start", {31'd0, bus1.period_start}, 32'd0);
        end
        check("rst pwm_out13", {16'd0, bus13.pwm_out}, 32'd0);
        rst = 1'b0;
        step();
        check("first edge static high", {16'd0, bus1.pwm_out}, 32'h0000FFFF);
        check("first edge period_start", {31'd0, bus1.period_start}, 32'd0);

        // 50% duty on channel 0; the first period runs with duty_sh=0.
        bus1.en_out = 16'h0001;
        bus1.en_pwm_mode = 16'h0001;
        run1(255, 0, 8'h00, highs, first_low, ps_cnt, last_ps, other_hi);
        check("first period highs", highs, 0);
        check("first period_start at 256", last_ps, 255);
        check("first period_start count", ps_cnt, 1);
        run1(256, 0, 8'h00, highs, first_low, ps_cnt, last_ps, other_hi);
        check("duty80 highs", highs, 128);
        check("duty80 first low", first_low, 129);
        check("duty80 period_start pos", last_ps, 256);
        check("duty80 period_start count", ps_cnt, 1);
        check("duty80 other bits", other_hi, 0);

        // duty 0 and 255 held over three periods.
        bus1.pwm_duty_cycle = 8'h00;
        wait_ps(1'b0, 300, "wait wrap duty00");
        run1(768, 0, 8'h00, highs, first_low, ps_cnt, last_ps, other_hi);
        check("duty00 highs", highs, 0);
        check("duty00 period_starts", ps_cnt, 3);
        bus1.pwm_duty_cycle = 8'hFF;
        wait_ps(1'b0, 300, "wait wrap dutyFF");
        run1(768, 0, 8'h00, highs, first_low, ps_cnt, last_ps, other_hi);
        check("dutyFF highs", highs, 768);
        check("dutyFF no dip", first_low, 0);
        check("dutyFF last period_start", last_ps, 768);

        // Duty written mid-period only takes effect after the boundary.
        bus1.pwm_duty_cycle = 8'h40;
        wait_ps(1'b0, 300, "wait wrap duty40");
        run1(256, 100, 8'hC0, highs, first_low, ps_cnt, last_ps, other_hi);
        check("duty40 kept highs", highs, 64);
        check("duty40 kept first low", first_low, 65);
        check("duty40 period_start", last_ps, 256);
        run1(256, 0, 8'h00, highs, first_low, ps_cnt, last_ps, other_hi);
        check("dutyC0 highs", highs, 192);
        check("dutyC0 first low", first_low, 193);
        cur_duty = 8'hC0;

        // Enable/mode table; enables are not shadowed, so one edge suffices.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].duty != cur_duty) begin
                bus1.pwm_duty_cycle = vecs[i].duty;
                wait_ps(1'b0, 300, "wait wrap table");
                cur_duty = vecs[i].duty;
            end
            bus1.en_out = vecs[i].en;
            bus1.en_pwm_mode = vecs[i].mode;
            step();
            check($sformatf("table vec %0d", i), {16'd0, bus1.pwm_out}, {16'd0, vecs[i].exp});
        end

        // Mixed channels at PRESCALE=13: one full 3328-cycle period.
        wait_ps(1'b1, 3400, "wait wrap prescale13");
        highs = 0; first_low = 0; bad = 0; ps_cnt = 0; last_ps = 0;
        for (int j = 1; j <= 3328; j++) begin
            step();
            v = bus13.pwm_out;
            if (v[11:0] != 12'h0F0) bad++;
            if (v[15:12] != 4'h0 && v[15:12] != 4'hF) bad++;
            if (v[15]) highs++;
            else if (first_low == 0) first_low = j;
            if (bus13.period_start) begin
                ps_cnt++;
                last_ps = j;
            end
        end
        check("p13 pwm highs", highs, 416);
        check("p13 first low", first_low, 417);
        check("p13 static bits", bad, 0);
        check("p13 period_start pos", last_ps, 3328);
        check("p13 period_start count", ps_cnt, 1);

        // Reset at pwm_cnt=150 aborts the period and clears the duty shadow.
        bus1.en_out = 16'h0001;
        bus1.en_pwm_mode = 16'h0001;
        bus1.pwm_duty_cycle = 8'h80;
        wait_ps(1'b0, 300, "wait wrap pre-reset");
        repeat (150) step();
        rst = 1'b1;
        step();
        check("midrst pwm_out", {16'd0, bus1.pwm_out}, 32'd0);
        check("midrst period_start", {31'd0, bus1.period_start}, 32'd0);
        check("midrst pwm_out13", {16'd0, bus13.pwm_out}, 32'd0);
        rst = 1'b0;
        run1(256, 0, 8'h00, highs, first_low, ps_cnt, last_ps, other_hi);
        check("post-rst period highs", highs, 0);
        check("post-rst period_start pos", last_ps, 256);
        check("post-rst period_start count", ps_cnt, 1);
        run1(256, 0, 8'h00, highs, first_low, ps_cnt, last_ps, other_hi);
        check("post-rst duty80 highs", highs, 128);
        check("post-rst duty80 first low", first_low, 129);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
